// File: rtl/booth_r4_pp_gen.sv
// booth_r4_pp_gen
//  Sequential radix-4 modified-Booth encoder / partial-product generator.
//  One signed md x mr pair is accepted in IDLE; the N/2 Booth partial
//  products are then emitted one per pp handshake. Each pp is sign-extended
//  to 2N bits and pre-shifted by 2*pp_idx, so their modulo-2^(2N) sum is md*mr.
//  Optional feature macro: ZERO_SKIP_EN (suppress zero digits except the last).
module booth_r4_pp_gen #(
  parameter  int N    = 64,
  localparam int IDXW = $clog2(N/2)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [N-1:0]  md,
  input  logic signed [N-1:0]  mr,
  output logic                 pp_valid,
  input  logic                 pp_ready,
  output logic [2*N-1:0]       pp,
  output logic [IDXW-1:0]      pp_idx,
  output logic                 pp_last
);

  localparam int NDIG = N / 2;
  localparam int WW   = N + 1;

  typedef enum logic {IDLE, GEN} state_t;

  state_t              state;
  logic signed [N-1:0] md_p0;
  logic [WW-1:0]       win_p0;

  logic                accept;
  logic                adv;
  logic                done;
  logic [WW-1:0]       base_win;
  logic signed [N-1:0] base_md;
  int                  base_k;
  int                  ofs;
  logic [WW-1:0]       nxt_win;
  int                  nxt_k;
  logic [2*N-1:0]      nxt_pp;

  // Booth digit value at N+2 bits so that -2*(-2^(N-1)) still fits
  function automatic logic signed [N+1:0] booth_digit(input logic signed [N-1:0] m,
                                                      input logic [2:0] b);
    logic signed [N+1:0] m_ext;
    logic signed [N+1:0] d;
    m_ext = {{2{m[N-1]}}, m};
    case (b)
      3'b001, 3'b010: d = m_ext;
      3'b011:         d = m_ext <<< 1;
      3'b100:         d = -(m_ext <<< 1);
      3'b101, 3'b110: d = -m_ext;
      default:        d = '0;
    endcase
    return d;
  endfunction

  // Sign-extend the digit value to 2N bits and weight it by 4^k
  function automatic logic [2*N-1:0] pp_value(input logic signed [N-1:0] m,
                                              input logic [2:0] b,
                                              input int k);
    logic signed [N+1:0]   d;
    logic signed [2*N-1:0] ext;
    d   = booth_digit(m, b);
    ext = {{(N-2){d[N+1]}}, d};
    return ext << (2 * k);
  endfunction

`ifdef ZERO_SKIP_EN
  function automatic logic is_zero_digit(input logic [2:0] b);
    return (b == 3'b000) || (b == 3'b111);
  endfunction

  // Distance (in digits) from the current window position to the next digit
  // to emit: first non-zero digit at or beyond first_ofs, else the last digit.
  // Scanned downwards so the nearest qualifying digit wins.
  function automatic int skip_ofs(input logic [WW-1:0] w, input int k, input int first_ofs);
    int r;
    r = NDIG - 1 - k;
    for (int d = NDIG - 1; d >= 0; d--) begin
      if (d >= first_ofs && (k + d) <= NDIG - 1 && !is_zero_digit(w[2*d +: 3]))
        r = d;
    end
    return r;
  endfunction
`endif

  assign in_ready = (state == IDLE);

  // Select the source window/index and compute the next digit to present
  always_comb begin
    accept   = (state == IDLE) && in_valid;
    adv      = (state == GEN) && pp_valid && pp_ready && !pp_last;
    done     = (state == GEN) && pp_valid && pp_ready && pp_last;
    base_win = accept ? {mr, 1'b0} : win_p0;
    base_md  = accept ? md : md_p0;
    base_k   = accept ? 0 : int'(pp_idx);
`ifdef ZERO_SKIP_EN
    ofs      = skip_ofs(base_win, base_k, accept ? 0 : 1);
`else
    ofs      = accept ? 0 : 1;
`endif
    nxt_win  = base_win >> (2 * ofs);
    nxt_k    = base_k + ofs;
    nxt_pp   = pp_value(base_md, nxt_win[2:0], nxt_k);
  end

  // Control FSM plus registered operand, window and pp outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      md_p0    <= '0;
      win_p0   <= '0;
      pp_valid <= 1'b0;
      pp       <= '0;
      pp_idx   <= '0;
      pp_last  <= 1'b0;
    end else if (accept || adv) begin
      // stage p0: window advances, next digit registered onto the pp outputs
      state    <= GEN;
      if (accept) md_p0 <= md;
      win_p0   <= nxt_win;
      pp_valid <= 1'b1;
      pp       <= nxt_pp;
      pp_idx   <= IDXW'(nxt_k);
      pp_last  <= (nxt_k == NDIG - 1);
    end else if (done) begin
      state    <= IDLE;
      pp_valid <= 1'b0;
      pp_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_booth_r4_pp_gen.sv
// Scoreboard bench for booth_r4_pp_gen: an N=8 instance for directed cases
// and short random runs, an N=64 instance for random pairs. Expected beats
// and products are pushed when a pair is driven and popped by per-DUT monitors.
module tb_booth_r4_pp_gen;

  typedef struct {
    int           idx;
    logic [127:0] pp;
    bit           last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic         iv8, ir8, pv8, pr8, pl8;
  logic [7:0]   md8, mr8;
  logic [15:0]  pp8;
  logic [1:0]   idx8;

  logic         iv64, ir64, pv64, pr64, pl64;
  logic [63:0]  md64, mr64;
  logic [127:0] pp64;
  logic [4:0]   idx64;

  int n_checks = 0;
  int n_fail   = 0;
  int done8    = 0;
  int done64   = 0;
  bit stall8   = 0;
  bit stall64  = 0;

  beat_t        q8[$], q64[$];
  logic [127:0] s8[$], s64[$];
  logic [127:0] sum8, sum64;
  beat_t        e8, e64;

  booth_r4_pp_gen #(.N(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .md(md8), .mr(mr8),
    .pp_valid(pv8), .pp_ready(pr8), .pp(pp8), .pp_idx(idx8), .pp_last(pl8));

  booth_r4_pp_gen #(.N(64)) u_dut64 (
    .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(ir64), .md(md64), .mr(mr64),
    .pp_valid(pv64), .pp_ready(pr64), .pp(pp64), .pp_idx(idx64), .pp_last(pl64));

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: digit value from mr bits arithmetically, times sign-extended md
  task automatic push_model(input int n, input logic [127:0] md, input logic [127:0] mr,
                            input bit big, input bit with_sum);
    logic signed [127:0] mds, mrs, dv, ppv;
    logic [127:0]        mask, lowmask;
    logic [128:0]        win;
    logic [2:0]          b;
    int                  d;
    beat_t               bt;
    mask    = '1;
    mask    = mask >> (128 - 2*n);
    lowmask = mask >> n;
    mds = md; if (md[n-1]) mds = mds | ~lowmask;
    mrs = mr; if (mr[n-1]) mrs = mrs | ~lowmask;
    win = {1'b0, mr} << 1;
    for (int k = 0; k < n/2; k++) begin
      b  = win[2*k +: 3];
      d  = (b[0] ? 1 : 0) + (b[1] ? 1 : 0) - (b[2] ? 2 : 0);
      dv = d;
      ppv = (mds * dv) <<< (2*k);
`ifdef ZERO_SKIP_EN
      if (d == 0 && k != n/2 - 1) continue;
`endif
      bt.idx = k; bt.pp = ppv & mask; bt.last = (k == n/2 - 1);
      if (big) q64.push_back(bt); else q8.push_back(bt);
    end
    if (with_sum) begin
      if (big) s64.push_back((mds * mrs) & mask);
      else     s8.push_back((mds * mrs) & mask);
    end
  endtask

  task automatic push_beat8(input int idx, input logic [15:0] p, input bit last);
    beat_t bt;
    bt.idx = idx; bt.pp = 128'(p); bt.last = last;
    q8.push_back(bt);
  endtask

  // Monitor for the N=8 instance
  always @(negedge clk) begin
    if (!reset) sum8 = '0;
    else if (pv8 && pr8) begin
      if (q8.size() == 0) check_eq("beat8_unexpected", 128'(idx8), 128'hDEAD);
      else begin
        e8 = q8.pop_front();
        check_eq("pp_idx8", 128'(idx8), 128'(e8.idx));
        check_eq("pp8", 128'(pp8), e8.pp);
        check_eq("pp_last8", 128'(pl8), 128'(e8.last));
      end
      sum8 = sum8 + 128'(pp8);
      if (pl8) begin
        if (s8.size() == 0) check_eq("sum8_unexpected", sum8, 128'hDEAD);
        else check_eq("sum8", 128'(sum8[15:0]), s8.pop_front());
        sum8 = '0;
        done8++;
      end
    end
  end

  // Monitor for the N=64 instance
  always @(negedge clk) begin
    if (!reset) sum64 = '0;
    else if (pv64 && pr64) begin
      if (q64.size() == 0) check_eq("beat64_unexpected", 128'(idx64), 128'hDEAD);
      else begin
        e64 = q64.pop_front();
        check_eq("pp_idx64", 128'(idx64), 128'(e64.idx));
        check_eq("pp64", pp64, e64.pp);
        check_eq("pp_last64", 128'(pl64), 128'(e64.last));
      end
      sum64 = sum64 + pp64;
      if (pl64) begin
        if (s64.size() == 0) check_eq("sum64_unexpected", sum64, 128'hDEAD);
        else check_eq("sum64", sum64, s64.pop_front());
        sum64 = '0;
        done64++;
      end
    end
  end

  // Present a pair and wait for its accept; in_valid is left high for the caller
  task automatic send8(input logic [7:0] a, input logic [7:0] b);
    bit acc;
    int budget;
    md8 = a; mr8 = b; iv8 = 1'b1;
    acc = 0; budget = 200;
    while (!acc && budget > 0) begin
      @(negedge clk); acc = ir8;
      @(posedge clk); #1;
      if (stall8) pr8 = 1'($urandom_range(0, 1));
      budget--;
    end
    if (!acc) check_eq("accept8_timeout", 128'(0), 128'(1));
  endtask

  task automatic wait_done8(input int target);
    int budget;
    budget = 1000;
    while (done8 < target && budget > 0) begin
      @(posedge clk); #1;
      pr8 = stall8 ? 1'($urandom_range(0, 1)) : 1'b1;
      budget--;
    end
    if (done8 < target) check_eq("done8_timeout", 128'(done8), 128'(target));
    pr8 = 1'b1;
  endtask

  task automatic send64(input logic [63:0] a, input logic [63:0] b);
    bit acc;
    int budget;
    md64 = a; mr64 = b; iv64 = 1'b1;
    acc = 0; budget = 200;
    while (!acc && budget > 0) begin
      @(negedge clk); acc = ir64;
      @(posedge clk); #1;
      budget--;
    end
    if (!acc) check_eq("accept64_timeout", 128'(0), 128'(1));
    iv64 = 1'b0;
  endtask

  task automatic wait_done64(input int target);
    int budget;
    budget = 2000;
    while (done64 < target && budget > 0) begin
      @(posedge clk); #1;
      pr64 = stall64 ? 1'($urandom_range(0, 1)) : 1'b1;
      budget--;
    end
    if (done64 < target) check_eq("done64_timeout", 128'(done64), 128'(target));
    pr64 = 1'b1;
  endtask

  initial begin
    int budget;
    logic [7:0]  ra, rb;
    logic [63:0] wa, wb;

    reset = 1'b0;
    iv8 = 0; pr8 = 1; md8 = '0; mr8 = '0;
    iv64 = 0; pr64 = 1; md64 = '0; mr64 = '0;
    #12;
    check_eq("rst_pp_valid8", 128'(pv8), 128'(0));
    check_eq("rst_pp8", 128'(pp8), 128'(0));
    check_eq("rst_pp_idx8", 128'(idx8), 128'(0));
    check_eq("rst_pp_last8", 128'(pl8), 128'(0));
    check_eq("rst_pp_valid64", 128'(pv64), 128'(0));
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready8", 128'(ir8), 128'(1));
    @(posedge clk); #1;

    // md=3, mr=5
`ifdef ZERO_SKIP_EN
    push_beat8(0, 16'h0003, 0); push_beat8(1, 16'h000C, 0); push_beat8(3, 16'h0000, 1);
`else
    push_beat8(0, 16'h0003, 0); push_beat8(1, 16'h000C, 0);
    push_beat8(2, 16'h0000, 0); push_beat8(3, 16'h0000, 1);
`endif
    s8.push_back(128'd15);
    send8(8'd3, 8'd5); iv8 = 1'b0;
    @(negedge clk);
    check_eq("first_beat_valid8", 128'(pv8), 128'(1));
    check_eq("first_beat_idx8", 128'(idx8), 128'(0));
    check_eq("gen_in_ready8", 128'(ir8), 128'(0));
    wait_done8(1);

    // md=-128, mr=-128
`ifndef ZERO_SKIP_EN
    push_beat8(0, 16'h0000, 0); push_beat8(1, 16'h0000, 0); push_beat8(2, 16'h0000, 0);
`endif
    push_beat8(3, 16'h4000, 1);
    s8.push_back(128'd16384);
    send8(8'h80, 8'h80); iv8 = 1'b0;
    wait_done8(2);

    // stall three cycles on idx1
    push_model(8, 128'd3, 128'd5, 0, 1);
    send8(8'd3, 8'd5); iv8 = 1'b0;
    @(posedge clk); #1 pr8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_valid8", 128'(pv8), 128'(1));
      check_eq("stall_idx8", 128'(idx8), 128'(1));
      check_eq("stall_pp8", 128'(pp8), 128'h000C);
      check_eq("stall_last8", 128'(pl8), 128'(0));
      @(posedge clk); #1;
    end
    pr8 = 1'b1;
    wait_done8(3);

    // reset during idx2, then md=-1, mr=1
    push_model(8, 128'd3, 128'h15, 0, 0);
    send8(8'd3, 8'h15); iv8 = 1'b0;
    budget = 20;
    while (!(pv8 && idx8 == 2'd2) && budget > 0) begin
      @(negedge clk); budget--;
    end
    check_eq("reach_idx2", 128'(idx8), 128'(2));
    reset = 1'b0;
    #1;
    check_eq("abort_pp_valid8", 128'(pv8), 128'(0));
    check_eq("abort_pp_idx8", 128'(idx8), 128'(0));
    check_eq("abort_pp_last8", 128'(pl8), 128'(0));
    q8.delete(); s8.delete();
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready8", 128'(ir8), 128'(1));
    check_eq("post_rst_pp_valid8", 128'(pv8), 128'(0));
    @(posedge clk); #1;
    push_model(8, 128'hFF, 128'h01, 0, 0);
    s8.push_back(128'hFFFF);
    send8(8'hFF, 8'h01); iv8 = 1'b0;
    wait_done8(4);

    // in_valid held during GEN with a different pair
    push_model(8, 128'd5, 128'd7, 0, 1);
    push_model(8, 128'hFD, 128'd9, 0, 1);
    send8(8'd5, 8'd7);
    send8(8'hFD, 8'd9);
    iv8 = 1'b0;
    wait_done8(6);

    // mr=0
`ifdef ZERO_SKIP_EN
    push_beat8(3, 16'h0000, 1);
`else
    push_beat8(0, 16'h0000, 0); push_beat8(1, 16'h0000, 0);
    push_beat8(2, 16'h0000, 0); push_beat8(3, 16'h0000, 1);
`endif
    s8.push_back(128'd0);
    send8(8'd3, 8'd0); iv8 = 1'b0;
    wait_done8(7);

    // random N=8 with random backpressure
    stall8 = 1;
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      push_model(8, 128'(ra), 128'(rb), 0, 1);
      send8(ra, rb); iv8 = 1'b0;
      wait_done8(8 + i);
    end
    stall8 = 0;

    // random N=64 with random backpressure, plus extreme corners
    stall64 = 1;
    for (int i = 0; i < 200; i++) begin
      wa = {$urandom, $urandom}; wb = {$urandom, $urandom};
      if (i == 0) begin wa = 64'h8000_0000_0000_0000; wb = 64'h8000_0000_0000_0000; end
      if (i == 1) begin wa = '1; wb = 64'h7FFF_FFFF_FFFF_FFFF; end
      push_model(64, 128'(wa), 128'(wb), 1, 1);
      send64(wa, wb);
      wait_done64(1 + i);
    end

    check_eq("q8_drained", 128'(q8.size()), 128'(0));
    check_eq("q64_drained", 128'(q64.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
